// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Definitions shared by the instruction-memory loader and its byte assembler:
// the loader FSM state encoding, the default end-of-program marker and the
// number of UART bytes that make up one instruction word.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Packs a UART byte stream into little-endian words. The first byte of a word
// lands in the least significant byte. When the last byte of a word arrives,
// o_word_valid pulses for one cycle on the following cycle, with o_word
// holding the complete word.
//
// Ports:
//   clk          in   clock
//   i_rst        in   synchronous active-high reset
//   i_clear      in   discard any partial word and restart at byte 0
//   i_enable     in   bytes are accepted only while high
//   i_rx_valid   in   i_rx_data carries a new byte
//   i_rx_data    in   received byte
//   o_word_valid out  one-cycle pulse: o_word is a complete word
//   o_word       out  assembly register
// -----------------------------------------------------------------------------
module byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_word_valid,
    output logic [NB_DATA-1:0] o_word
);

    localparam int NB_CNT = $clog2(BYTES_PER_WORD);

    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic [NB_DATA-1:0] word_q, word_d;
    logic               word_valid_q, word_valid_d;

    always_comb begin
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        // A clear also swallows a byte arriving in the same cycle.
        if (i_clear) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (i_enable && i_rx_valid) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (cnt_q == NB_CNT'(k)) begin
                    word_d[k*NB_BYTE +: NB_BYTE] = i_rx_data;
                end
            end
            if (cnt_q == NB_CNT'(BYTES_PER_WORD - 1)) begin
                cnt_d        = '0;
                word_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    // The register still holds the finished word during the valid cycle; a
    // byte accepted in that cycle only overwrites byte 0 at the next edge.
    assign o_word_valid = word_valid_q;
    assign o_word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory. Assembles little-endian 32-bit words
// from the debug UART byte stream and writes them to consecutive word
// addresses from 0, stopping after the halt word or when memory is full.
//
// Ports:
//   clk          in   clock
//   i_rst        in   synchronous active-high reset
//   i_start      in   one-cycle pulse, begins or restarts a load
//   i_rx_valid   in   i_rx_data carries a new byte
//   i_rx_data    in   received byte
//   o_mem_we     out  one-cycle instruction-memory write strobe
//   o_mem_addr   out  word-aligned byte address of the write
//   o_mem_data   out  word to write
//   o_busy       out  loading
//   o_done       out  load finished
//   o_full       out  load ended on capacity rather than the halt word
//   o_word_count out  words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                 NB_DATA   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 NB_ADDR   = 10,
    parameter int                 MEM_WORDS = 256,
    parameter logic [NB_DATA-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_rx_valid,
    input  logic [NB_BYTE-1:0] i_rx_data,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_full,
    output logic [NB_ADDR-2:0] o_word_count
);

    localparam int NB_CNT = NB_ADDR - 1;

    state_t            state_q, state_d;
    logic [NB_CNT-1:0] count_q, count_d;
    logic              full_q, full_d;
    logic              load_en;
    logic              word_valid;
    logic [NB_DATA-1:0] word;

    assign load_en = (state_q == LOAD);

    byte_assembler #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_byte_assembler (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_clear      (i_start),
        .i_enable     (load_en),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        full_d  = full_q;
        // Restart beats everything, including termination on a write that
        // is completing in this very cycle.
        if (i_start) begin
            state_d = LOAD;
            count_d = '0;
            full_d  = 1'b0;
        end else if (load_en && word_valid) begin
            count_d = count_q + NB_CNT'(1);
            if (word == HALT_WORD) begin
                state_d = DONE;
            end else if (count_q == NB_CNT'(MEM_WORDS - 1)) begin
                state_d = DONE;
                full_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // The write address is the count before this write bumps it.
    assign o_mem_we     = word_valid;
    assign o_mem_addr   = {count_q[NB_ADDR-3:0], 2'b00};
    assign o_mem_data   = word;
    assign o_busy       = (state_q == LOAD);
    assign o_done       = (state_q == DONE);
    assign o_full       = full_q;
    assign o_word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_data;
    logic        o_busy, o_done, o_full;
    logic [8:0]  o_word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];

    // Reference model: 0 idle, 1 loading, 2 done.
    int         m_state = 0;
    logic [7:0] m_bytes[$];
    int         m_count = 0;
    bit         m_full = 1'b0;

    imem_loader dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_full       (o_full),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_mem_we) obs_q.push_back({32'(cyc), o_mem_addr, o_mem_data});
    end

    // Applies the rules to one cycle of inputs presented in cycle c; a
    // completed word is expected on the write port during cycle c+1.
    function automatic void model_step(bit st, bit v, logic [7:0] d, bit r, int c);
        logic [31:0] w;
        if (r) begin
            m_state = 0; m_bytes.delete(); m_count = 0; m_full = 1'b0;
            return;
        end
        if (st) begin
            m_state = 1; m_bytes.delete(); m_count = 0; m_full = 1'b0;
            return;
        end
        if (m_state == 1 && v) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                exp_q.push_back({32'(c + 1), 10'(m_count * 4), w});
                m_bytes.delete();
                if (w == 32'hFFFF_FFFF) begin
                    m_state = 2; m_full = 1'b0;
                end else if (m_count == 255) begin
                    m_state = 2; m_full = 1'b1;
                end
                m_count++;
            end
        end
    endfunction

    task automatic step(bit st, bit v, logic [7:0] d, bit r);
        @(negedge clk);
        i_start = st; i_rx_valid = v; i_rx_data = d; i_rst = r;
        model_step(st, v, d, r, cyc);
    endtask

    task automatic send(logic [7:0] d, int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int i = 0; i < gap; i++) step(0, 0, 8'h00, 0);
        step(0, 1, d, 0);
    endtask

    task automatic send_word(logic [31:0] w, int max_gap);
        for (int b = 0; b < 4; b++) send(w[b*8 +: 8], max_gap);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        checks++;
        if ({o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_full, o_word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b done=%b full=%b cnt=%0d, required all zero",
                     o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_full, o_word_count);
        end
        for (int i = 0; i < 4; i++) step(0, 1, 8'(i + 1), 0);
        flush();
        checks++;
        if (obs_q.size() != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores_bytes: got %0d writes busy=%b, required 0 writes busy=0",
                     obs_q.size(), o_busy);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic_program();
        step(1, 0, 8'h00, 0);
        send_word(32'h0000_0013, 2);
        send_word(32'hDEAD_BEEF, 2);
        send_word(32'hFFFF_FFFF, 2);
        flush();
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 3) begin
            errors++;
            $display("FAIL basic_write_count: got %0d writes, required 3 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (obs_q.size() == 3 && (obs_q[0].data !== 32'h0000_0013 || obs_q[1].data !== 32'hDEAD_BEEF ||
            obs_q[2].addr !== 10'h008)) begin
            errors++;
            $display("FAIL basic_literals: got w0=%h w1=%h a2=%h, required 00000013 deadbeef 008",
                     obs_q[0].data, obs_q[1].data, obs_q[2].addr);
        end
        checks++;
        if (o_done !== 1'b1 || o_full !== 1'b0 || o_busy !== 1'b0 || o_word_count !== 9'd3) begin
            errors++;
            $display("FAIL basic_final: got done=%b full=%b busy=%b cnt=%0d, required 1 0 0 3",
                     o_done, o_full, o_busy, o_word_count);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_done_ignores();
        for (int i = 0; i < 9; i++) send(8'($urandom), 1);
        flush();
        checks++;
        if (obs_q.size() != 0 || o_word_count !== 9'(m_count) || o_done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_bytes: got %0d writes cnt=%0d done=%b, required 0 writes cnt=%0d done=1",
                     obs_q.size(), o_word_count, o_done, m_count);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        step(1, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0);
        flush();
        checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_write_count: got %0d writes, required 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_write%0d: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                         i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++;
        if (obs_q.size() == 2 && (obs_q[0].data !== 32'h0403_0201 || obs_q[1].data !== 32'h0807_0605)) begin
            errors++;
            $display("FAIL b2b_literals: got %h %h, required 04030201 08070605", obs_q[0].data, obs_q[1].data);
        end
        checks++;
        if (o_busy !== 1'b1 || o_word_count !== 9'd2) begin
            errors++;
            $display("FAIL b2b_state: got busy=%b cnt=%0d, required busy=1 cnt=2", o_busy, o_word_count);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_fill_memory();
        logic [31:0] w;
        int bad;
        step(1, 0, 8'h00, 0);
        for (int n = 0; n < 256; n++) begin
            w = {8'($urandom_range(0, 254)), 24'($urandom)};
            send_word(w, ($urandom_range(0, 7) == 0) ? 1 : 0);
        end
        flush();
        checks++;
        if (obs_q.size() != 256 || exp_q.size() != 256) begin
            errors++;
            $display("FAIL fill_write_count: got %0d writes, required 256", obs_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                if (bad == 0)
                    $display("FAIL fill_write%0d: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                             i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (obs_q.size() > 0 && obs_q[obs_q.size()-1].addr !== 10'h3FC) begin
            errors++;
            $display("FAIL fill_last_addr: got %h, required 3fc", obs_q[obs_q.size()-1].addr);
        end
        checks++;
        if (o_done !== 1'b1 || o_full !== 1'b1 || o_word_count !== 9'd256) begin
            errors++;
            $display("FAIL fill_final: got done=%b full=%b cnt=%0d, required 1 1 256", o_done, o_full, o_word_count);
        end
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 0);
        flush();
        checks++;
        if (obs_q.size() != 0 || o_word_count !== 9'd256) begin
            errors++;
            $display("FAIL fill_after_full: got %0d writes cnt=%0d, required 0 writes cnt=256",
                     obs_q.size(), o_word_count);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_restart_mid_word();
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'hAA, 0);
        step(0, 1, 8'hBB, 0);
        step(1, 1, 8'hCC, 0);
        for (int i = 1; i <= 4; i++) send(8'(i), 1);
        flush();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL restart_write_count: got %0d writes, required 1", obs_q.size());
        end
        checks++;
        if (obs_q.size() >= 1 && (obs_q[0] !== exp_q[0] || obs_q[0].addr !== 10'h000 ||
            obs_q[0].data !== 32'h0403_0201)) begin
            errors++;
            $display("FAIL restart_write: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=000 data=04030201",
                     obs_q[0].cyc, obs_q[0].addr, obs_q[0].data, exp_q[0].cyc);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 1);
        flush();
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_cancels_write: got %0d writes, required 0", obs_q.size());
        end
        checks++;
        if ({o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_full, o_word_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h data=%h busy=%b done=%b full=%b cnt=%0d, required all zero",
                     o_mem_we, o_mem_addr, o_mem_data, o_busy, o_done, o_full, o_word_count);
        end
        for (int i = 0; i < 8; i++) step(0, 1, 8'($urandom), 0);
        flush();
        checks++;
        if (obs_q.size() != 0 || o_word_count !== 9'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_bytes: got %0d writes cnt=%0d busy=%b, required 0 0 0",
                     obs_q.size(), o_word_count, o_busy);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_stream();
        bit st, v, r;
        logic [7:0] d;
        int bad;
        step(0, 0, 8'h00, 1);
        for (int n = 0; n < 1500; n++) begin
            st = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 2) != 0);
            d  = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            step(st, v, d, r);
        end
        flush();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_write_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                if (bad == 0)
                    $display("FAIL random_write%0d: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                             i, obs_q[i].cyc, obs_q[i].addr, obs_q[i].data, exp_q[i].cyc, exp_q[i].addr, exp_q[i].data);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (o_busy !== (m_state == 1) || o_done !== (m_state == 2) || o_full !== m_full ||
            o_word_count !== 9'(m_count)) begin
            errors++;
            $display("FAIL random_final: got busy=%b done=%b full=%b cnt=%0d, required %b %b %b %0d",
                     o_busy, o_done, o_full, o_word_count, m_state == 1, m_state == 2, m_full, m_count);
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_program();
        test_done_ignores();
        test_back_to_back();
        test_fill_memory();
        test_restart_mid_word();
        test_reset_mid_load();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
